cpu_axi_bridge: RTL and testbench

//  Sits directly downstream of mycpu_top: converts its two SRAM-like ports (inst, data) into one AXI3 32-bit master.

---
 rtl/cpu_axi_pkg.sv | 22 ++
 rtl/cpu_axi_if.sv | 73 +++++++
 rtl/cpu_axi_wr_ch.sv | 71 +++++++
 rtl/cpu_axi_bridge.sv | 130 +++++++++++++
 tb/tb_cpu_axi_bridge.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_axi_pkg.sv
// Shared constants for the CPU-to-AXI bridge: IDs, burst/size encodings, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cpu_axi_pkg;

  localparam logic [3:0] ID_INST        = 4'd0;
  localparam logic [3:0] ID_DATA        = 4'd1;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic {AR_IDLE, AR_SEND} ar_state_t;
  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;

  // CPU size code maps straight onto AXI AxSIZE (bytes = 2**size)
  function automatic logic [2:0] axi_size(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/cpu_axi_if.sv
// AXI3 32-bit bus bundle between the bridge (master) and the memory/SoC (slave).
// Latency: n/a (wires only).
// Backpressure: standard AXI valid/ready on every channel.
interface cpu_axi_if;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/cpu_axi_wr_ch.sv
// Single-beat data write engine: drives AW and W together, waits for B, reports completion.
// Latency: AW/W valid the cycle after start; done in the cycle bvalid is taken.
// Backpressure: AW/W held until their own ready; B deferred (bready=0) while b_hold is high.
module cpu_axi_wr_ch
  import cpu_axi_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  input  logic        b_hold,
  output logic        busy,
  output logic [29:0] pend_word,
  output logic        done,
  cpu_axi_if.master   axi
);

  w_state_t state;

  assign axi.awid    = ID_DATA;
  assign axi.awlen   = 8'd0;
  assign axi.awburst = AXI_BURST_INCR;
  assign axi.awlock  = 2'b00;
  assign axi.awcache = 4'b0000;
  assign axi.awprot  = 3'b000;
  assign axi.wid     = ID_DATA;
  assign axi.wlast   = 1'b1;
  // a data read response owns data_ok this cycle, so the write response waits
  assign axi.bready  = !b_hold;

  assign busy      = (state != W_IDLE);
  assign pend_word = axi.awaddr[31:2];
  assign done      = (state == W_RESP) && axi.bvalid && axi.bready;

  // Write FSM: launch AW+W, retire each on its own handshake, then wait for B
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= W_IDLE;
      axi.awvalid <= 1'b0;
      axi.wvalid  <= 1'b0;
      axi.awaddr  <= '0;
      axi.awsize  <= '0;
      axi.wdata   <= '0;
      axi.wstrb   <= '0;
    end else begin
      case (state)
        W_IDLE: if (start) begin
          axi.awvalid <= 1'b1;
          axi.wvalid  <= 1'b1;
          axi.awaddr  <= addr;
          axi.awsize  <= axi_size(size);
          axi.wdata   <= wdata;
          axi.wstrb   <= wstrb;
          state       <= W_SEND;
        end
        W_SEND: begin
          if (axi.awready) axi.awvalid <= 1'b0;
          if (axi.wready)  axi.wvalid  <= 1'b0;
          if ((!axi.awvalid || axi.awready) && (!axi.wvalid || axi.wready))
            state <= W_RESP;
        end
        W_RESP: if (axi.bvalid && axi.bready) state <= W_IDLE;
        default: state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cpu_axi_bridge.sv
// Joins the CPU inst/data SRAM-like ports onto one AXI3 master; optional BRIDGE_RAW_ADDR_EN relaxes read blocking.
// Latency: addr_ok combinational with req; read data_ok >= 2 cycles after accept; write data_ok on the B cycle.
// Backpressure: addr_ok withheld while AR busy, same-ID read outstanding, write hazard, or write engine busy.
module cpu_axi_bridge
  import cpu_axi_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  cpu_axi_if.master   axi
);

  ar_state_t   ar_state;
  logic        active;
  logic        inst_pend, data_pend;
  logic        w_busy, w_done, wr_start;
  logic [29:0] w_word;
  logic        inst_raw_ok, data_raw_ok;
  logic        data_rd_acc, inst_rd_acc;
  logic        r_inst, r_data;

  wire unused_ok = &{1'b0, inst_wr, axi.rresp, axi.rlast, axi.bid, axi.bresp};

`ifdef BRIDGE_RAW_ADDR_EN
  assign inst_raw_ok = !(w_busy && (w_word == inst_addr[31:2]));
  assign data_raw_ok = !(w_busy && (w_word == data_addr[31:2]));
`else
  assign inst_raw_ok = !w_busy;
  assign data_raw_ok = !w_busy;
  wire [29:0] unused_w_word = w_word;
`endif

  assign data_rd_acc = active && (ar_state == AR_IDLE) && data_req && !data_wr && !data_pend && data_raw_ok;
  assign inst_rd_acc = active && (ar_state == AR_IDLE) && inst_req && !inst_pend && inst_raw_ok && !data_rd_acc;
  assign wr_start    = active && !w_busy && data_req && data_wr;

  assign inst_addr_ok = inst_rd_acc;
  assign data_addr_ok = data_rd_acc || wr_start;

  // responses only count against a read we actually issued since reset
  assign r_inst       = axi.rvalid && (axi.rid == ID_INST) && inst_pend;
  assign r_data       = axi.rvalid && (axi.rid == ID_DATA) && data_pend;
  assign inst_data_ok = r_inst;
  assign data_data_ok = r_data || w_done;
  assign inst_rdata   = r_inst ? axi.rdata : '0;
  assign data_rdata   = r_data ? axi.rdata : '0;

  assign axi.arlen   = 8'd0;
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'b0000;
  assign axi.arprot  = 3'b000;
  assign axi.rready  = 1'b1;

  // Keep addr_ok low until the first clock after reset is released
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) active <= 1'b0;
    else         active <= 1'b1;
  end

  // Read address FSM: latch the winning request and hold it until arready
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ar_state    <= AR_IDLE;
      axi.arvalid <= 1'b0;
      axi.arid    <= '0;
      axi.araddr  <= '0;
      axi.arsize  <= '0;
    end else begin
      case (ar_state)
        AR_IDLE: if (data_rd_acc || inst_rd_acc) begin
          axi.arvalid <= 1'b1;
          axi.arid    <= data_rd_acc ? ID_DATA : ID_INST;
          axi.araddr  <= data_rd_acc ? data_addr : inst_addr;
          axi.arsize  <= axi_size(data_rd_acc ? data_size : inst_size);
          ar_state    <= AR_SEND;
        end
        AR_SEND: if (axi.arready) begin
          axi.arvalid <= 1'b0;
          ar_state    <= AR_IDLE;
        end
        default: ar_state <= AR_IDLE;
      endcase
    end
  end

  // One outstanding read per ID: set on accept, cleared by its R beat
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_pend <= 1'b0;
      data_pend <= 1'b0;
    end else begin
      if (inst_rd_acc)  inst_pend <= 1'b1;
      else if (r_inst)  inst_pend <= 1'b0;
      if (data_rd_acc)  data_pend <= 1'b1;
      else if (r_data)  data_pend <= 1'b0;
    end
  end

  cpu_axi_wr_ch u_wr_ch (
    .clk       (clk),
    .resetn    (resetn),
    .start     (wr_start),
    .addr      (data_addr),
    .size      (data_size),
    .wstrb     (data_wstrb),
    .wdata     (data_wdata),
    .b_hold    (r_data),
    .busy      (w_busy),
    .pend_word (w_word),
    .done      (w_done),
    .axi       (axi)
  );

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed bench for cpu_axi_bridge: reset, read arbitration, write channel, read/write hazards, reset abort.
// Latency: n/a (testbench).
// Backpressure: slave readies and responses are scripted cycle by cycle.
module tb_cpu_axi_bridge;
  import cpu_axi_pkg::*;

`ifdef BRIDGE_RAW_ADDR_EN
  localparam logic RAW = 1'b1;
`else
  localparam logic RAW = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_axi_if axi();

  cpu_axi_bridge dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_size    (inst_size),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wstrb   (data_wstrb),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .axi          (axi)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // inputs change 1 unit after the rising edge; outputs are sampled 2 units later
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = SIZE_WORD; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_size = SIZE_WORD; data_addr = '0;
    data_wstrb = 4'h0; data_wdata = '0;
    axi.arready = 1'b0; axi.rid = ID_INST; axi.rdata = '0; axi.rresp = 2'b00;
    axi.rlast = 1'b1; axi.rvalid = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0;
    axi.bid = ID_DATA; axi.bresp = 2'b00; axi.bvalid = 1'b0;
  endtask

  task automatic write_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    data_req = 1'b1; data_wr = 1'b1; data_addr = a; data_wdata = d;
    data_wstrb = s; data_size = SIZE_WORD;
  endtask

  initial begin
    // ---- reset state, with requests and responses already asserted
    idle_inputs();
    inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b1;
    axi.rvalid = 1'b1; axi.rdata = 32'hffffffff; axi.bvalid = 1'b1;
    repeat (2) cyc();
    settle();
    check_eq("rst_arvalid", axi.arvalid, 1'b0);
    check_eq("rst_awvalid", axi.awvalid, 1'b0);
    check_eq("rst_wvalid", axi.wvalid, 1'b0);
    check_eq("rst_inst_addr_ok", inst_addr_ok, 1'b0);
    check_eq("rst_data_addr_ok", data_addr_ok, 1'b0);
    check_eq("rst_inst_data_ok", inst_data_ok, 1'b0);
    check_eq("rst_data_data_ok", data_data_ok, 1'b0);
    check_eq("rst_inst_rdata", inst_rdata, 32'h0);
    check_eq("rst_rready", axi.rready, 1'b1);
    check_eq("rst_bready", axi.bready, 1'b1);
    idle_inputs();
    resetn = 1'b1;

    // ---- single instruction read, immediate slave
    cyc(); inst_req = 1'b1; inst_addr = 32'h1c000000; inst_size = SIZE_WORD; axi.arready = 1'b1; settle();
    check_eq("t1_inst_addr_ok", inst_addr_ok, 1'b1);
    check_eq("t1_data_addr_ok", data_addr_ok, 1'b0);
    cyc(); inst_req = 1'b0; settle();
    check_eq("t1_arvalid", axi.arvalid, 1'b1);
    check_eq("t1_arid", axi.arid, ID_INST);
    check_eq("t1_araddr", axi.araddr, 32'h1c000000);
    check_eq("t1_arsize", axi.arsize, 3'd2);
    check_eq("t1_arlen", axi.arlen, 8'd0);
    check_eq("t1_arburst", axi.arburst, 2'b01);
    cyc(); axi.rvalid = 1'b1; axi.rid = ID_INST; axi.rdata = 32'h12345678; settle();
    check_eq("t1_arvalid_drop", axi.arvalid, 1'b0);
    check_eq("t1_inst_data_ok", inst_data_ok, 1'b1);
    check_eq("t1_inst_rdata", inst_rdata, 32'h12345678);
    check_eq("t1_data_data_ok", data_data_ok, 1'b0);
    cyc(); axi.rvalid = 1'b0; settle();
    check_eq("t1_inst_data_ok_end", inst_data_ok, 1'b0);

    // ---- inst and data reads in the same cycle: data wins
    cyc(); inst_req = 1'b1; inst_addr = 32'h100; inst_size = SIZE_BYTE;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h202; data_size = SIZE_HALF; settle();
    check_eq("t2_data_addr_ok", data_addr_ok, 1'b1);
    check_eq("t2_inst_lost", inst_addr_ok, 1'b0);
    cyc(); data_req = 1'b0; settle();
    check_eq("t2_arid_data", axi.arid, ID_DATA);
    check_eq("t2_araddr_data", axi.araddr, 32'h202);
    check_eq("t2_arsize_half", axi.arsize, 3'd1);
    check_eq("t2_inst_wait_ar", inst_addr_ok, 1'b0);
    cyc(); axi.rvalid = 1'b1; axi.rid = ID_DATA; axi.rdata = 32'haaaa0001; settle();
    check_eq("t2_inst_addr_ok", inst_addr_ok, 1'b1);
    check_eq("t2_data_data_ok", data_data_ok, 1'b1);
    check_eq("t2_data_rdata", data_rdata, 32'haaaa0001);
    check_eq("t2_inst_data_ok_no", inst_data_ok, 1'b0);
    cyc(); inst_req = 1'b0; axi.rvalid = 1'b0; settle();
    check_eq("t2_arid_inst", axi.arid, ID_INST);
    check_eq("t2_araddr_inst", axi.araddr, 32'h100);
    check_eq("t2_arsize_byte", axi.arsize, 3'd0);
    cyc(); axi.rvalid = 1'b1; axi.rid = ID_INST; axi.rdata = 32'hbbbb0002; settle();
    check_eq("t2_inst_data_ok", inst_data_ok, 1'b1);
    check_eq("t2_inst_rdata", inst_rdata, 32'hbbbb0002);
    check_eq("t2_data_data_ok_no", data_data_ok, 1'b0);
    cyc(); axi.rvalid = 1'b0;

    // ---- write with late awready, immediate wready
    axi.awready = 1'b0; axi.wready = 1'b1;
    write_req(32'h1000, 32'hdeadbeef, 4'hf); settle();
    check_eq("t3_data_addr_ok", data_addr_ok, 1'b1);
    cyc(); data_req = 1'b0; settle();
    check_eq("t3_awvalid", axi.awvalid, 1'b1);
    check_eq("t3_wvalid", axi.wvalid, 1'b1);
    check_eq("t3_awaddr", axi.awaddr, 32'h1000);
    check_eq("t3_awid", axi.awid, ID_DATA);
    check_eq("t3_awsize", axi.awsize, 3'd2);
    check_eq("t3_wdata", axi.wdata, 32'hdeadbeef);
    check_eq("t3_wstrb", axi.wstrb, 4'hf);
    check_eq("t3_wlast", axi.wlast, 1'b1);
    check_eq("t3_wid", axi.wid, ID_DATA);
    cyc(); settle();
    check_eq("t3_wvalid_drop", axi.wvalid, 1'b0);
    check_eq("t3_awvalid_hold1", axi.awvalid, 1'b1);
    cyc(); settle();
    check_eq("t3_awvalid_hold2", axi.awvalid, 1'b1);
    cyc(); axi.awready = 1'b1; settle();
    check_eq("t3_awvalid_hold3", axi.awvalid, 1'b1);
    check_eq("t3_no_early_ok", data_data_ok, 1'b0);
    cyc(); axi.awready = 1'b0; axi.bvalid = 1'b1; settle();
    check_eq("t3_awvalid_drop", axi.awvalid, 1'b0);
    check_eq("t3_b_data_ok", data_data_ok, 1'b1);
    check_eq("t3_bready", axi.bready, 1'b1);
    cyc(); axi.bvalid = 1'b0; axi.wready = 1'b0; settle();
    check_eq("t3_data_ok_end", data_data_ok, 1'b0);

    // ---- read of another word while a write to 0x1000 is pending
    cyc(); write_req(32'h1000, 32'h11111111, 4'hf); axi.arready = 1'b1; settle();
    check_eq("t4_wr_accept", data_addr_ok, 1'b1);
    cyc(); data_req = 1'b0; inst_req = 1'b1; inst_addr = 32'h1004; inst_size = SIZE_WORD; settle();
    check_eq("t4_rd_during_wr", inst_addr_ok, RAW);
    cyc(); inst_req = !RAW; settle();
    check_eq("t4_ar_during_wr", axi.arvalid, RAW);
    check_eq("t4_awvalid_pending", axi.awvalid, 1'b1);
    cyc(); axi.awready = 1'b1; axi.wready = 1'b1;
    axi.rvalid = RAW; axi.rid = ID_INST; axi.rdata = 32'hc0de0001; settle();
    check_eq("t4_rd_blocked_send", inst_addr_ok, 1'b0);
    check_eq("t4_early_data_ok", inst_data_ok, RAW);
    cyc(); axi.awready = 1'b0; axi.wready = 1'b0; axi.rvalid = 1'b0; axi.bvalid = 1'b1; settle();
    check_eq("t4_b_data_ok", data_data_ok, 1'b1);
    check_eq("t4_rd_blocked_resp", inst_addr_ok, 1'b0);
    cyc(); axi.bvalid = 1'b0; settle();
    check_eq("t4_rd_after_b", inst_addr_ok, !RAW);
    cyc(); inst_req = 1'b0; settle();
    check_eq("t4_ar_after_b", axi.arvalid, !RAW);
    check_eq("t4_araddr", axi.araddr, 32'h1004);
    cyc(); axi.rvalid = !RAW; axi.rid = ID_INST; axi.rdata = 32'hc0de0002; settle();
    check_eq("t4_late_data_ok", inst_data_ok, !RAW);
    cyc(); axi.rvalid = 1'b0;

    // ---- read of the same word as a pending write: blocked until B in both builds
    write_req(32'h1000, 32'h22222222, 4'hf); settle();
    check_eq("t5_wr_accept", data_addr_ok, 1'b1);
    cyc(); data_req = 1'b0; inst_req = 1'b1; inst_addr = 32'h1000; settle();
    check_eq("t5_blocked_send", inst_addr_ok, 1'b0);
    cyc(); axi.awready = 1'b1; axi.wready = 1'b1; settle();
    check_eq("t5_blocked_hs", inst_addr_ok, 1'b0);
    cyc(); axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b1; settle();
    check_eq("t5_blocked_resp", inst_addr_ok, 1'b0);
    check_eq("t5_b_data_ok", data_data_ok, 1'b1);
    cyc(); axi.bvalid = 1'b0; settle();
    check_eq("t5_rd_accept", inst_addr_ok, 1'b1);
    cyc(); inst_req = 1'b0; settle();
    check_eq("t5_arvalid", axi.arvalid, 1'b1);
    check_eq("t5_araddr", axi.araddr, 32'h1000);
    cyc(); axi.rvalid = 1'b1; axi.rid = ID_INST; axi.rdata = 32'h0f0f0f0f; settle();
    check_eq("t5_inst_data_ok", inst_data_ok, 1'b1);
    check_eq("t5_inst_rdata", inst_rdata, 32'h0f0f0f0f);
    cyc(); axi.rvalid = 1'b0;

    // ---- B and data R in the same cycle: R first, B held one cycle
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h300; data_size = SIZE_WORD; settle();
    check_eq("t6_rd_accept", data_addr_ok, 1'b1);
    cyc(); write_req(32'h400, 32'h33333333, 4'h3); axi.awready = 1'b1; axi.wready = 1'b1; settle();
    check_eq("t6_wr_accept", data_addr_ok, 1'b1);
    cyc(); data_req = 1'b0; settle();
    check_eq("t6_awvalid", axi.awvalid, 1'b1);
    check_eq("t6_wstrb", axi.wstrb, 4'h3);
    cyc(); axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b1;
    axi.rvalid = 1'b1; axi.rid = ID_DATA; axi.rdata = 32'h55aa55aa; settle();
    check_eq("t6_r_data_ok", data_data_ok, 1'b1);
    check_eq("t6_r_rdata", data_rdata, 32'h55aa55aa);
    check_eq("t6_bready_held", axi.bready, 1'b0);
    cyc(); axi.rvalid = 1'b0; settle();
    check_eq("t6_bready_back", axi.bready, 1'b1);
    check_eq("t6_b_data_ok", data_data_ok, 1'b1);
    check_eq("t6_b_rdata_zero", data_rdata, 32'h0);
    cyc(); axi.bvalid = 1'b0; settle();
    check_eq("t6_data_ok_end", data_data_ok, 1'b0);

    // ---- reset while AR_SEND and W_RESP are both active
    cyc(); axi.arready = 1'b0; inst_req = 1'b1; inst_addr = 32'h2000; inst_size = SIZE_WORD; settle();
    check_eq("t7_rd_accept", inst_addr_ok, 1'b1);
    cyc(); inst_req = 1'b0; write_req(32'h500, 32'h44444444, 4'hf);
    axi.awready = 1'b1; axi.wready = 1'b1; settle();
    check_eq("t7_wr_accept", data_addr_ok, 1'b1);
    cyc(); data_req = 1'b0; settle();
    check_eq("t7_arvalid", axi.arvalid, 1'b1);
    check_eq("t7_awvalid", axi.awvalid, 1'b1);
    cyc(); axi.awready = 1'b0; axi.wready = 1'b0; settle();
    check_eq("t7_ar_send_held", axi.arvalid, 1'b1);
    check_eq("t7_in_w_resp", axi.awvalid, 1'b0);
    resetn = 1'b0; axi.rvalid = 1'b1; axi.rid = ID_INST; axi.rdata = 32'h77777777; axi.bvalid = 1'b1; settle();
    check_eq("t7_rst_arvalid", axi.arvalid, 1'b0);
    check_eq("t7_rst_awvalid", axi.awvalid, 1'b0);
    check_eq("t7_rst_wvalid", axi.wvalid, 1'b0);
    check_eq("t7_rst_inst_data_ok", inst_data_ok, 1'b0);
    check_eq("t7_rst_data_data_ok", data_data_ok, 1'b0);
    cyc(); resetn = 1'b1; settle();
    check_eq("t7_post_inst_data_ok", inst_data_ok, 1'b0);
    check_eq("t7_post_data_data_ok", data_data_ok, 1'b0);
    cyc(); settle();
    check_eq("t7_post2_inst_data_ok", inst_data_ok, 1'b0);
    check_eq("t7_post2_data_data_ok", data_data_ok, 1'b0);
    check_eq("t7_post2_arvalid", axi.arvalid, 1'b0);
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
